// File: rtl/vga_timing_gen.sv
// Parametrised VGA timing generator: pixel prescaler, col/row/frame counters,
// sync/blank decode and pixel/line/frame strobes, all outputs registered.
// Optional colour-bar test pattern on pat_rgb when VGA_TEST_PATTERN_EN is defined.
module vga_timing_gen #(
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned H_FP     = 16,
    parameter int unsigned H_SYNC   = 96,
    parameter int unsigned H_BP     = 48,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned V_FP     = 10,
    parameter int unsigned V_SYNC   = 2,
    parameter int unsigned V_BP     = 33,
    parameter int unsigned PIX_DIV  = 2,
    parameter int unsigned HS_POL   = 0,
    parameter int unsigned VS_POL   = 0,
    parameter int unsigned FCNT_W   = 16
) (
    input  logic              CLOCK_50,
    input  logic              reset,
    input  logic              en,
    output logic              HS,
    output logic              VS,
    output logic              blank,
    output logic [9:0]        row,
    output logic [10:0]       col,
    output logic              pix_en,
    output logic              line_start,
    output logic              frame_start,
    output logic [FCNT_W-1:0] frame_cnt,
    output logic [23:0]       pat_rgb
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int unsigned HS_BEG  = H_ACTIVE + H_FP;
    localparam int unsigned HS_END  = HS_BEG + H_SYNC;
    localparam int unsigned VS_BEG  = V_ACTIVE + V_FP;
    localparam int unsigned VS_END  = VS_BEG + V_SYNC;
    localparam int unsigned DIV_W   = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;
    localparam logic        HS_ON   = 1'(HS_POL);
    localparam logic        VS_ON   = 1'(VS_POL);

    // Reject parameter sets the counters cannot represent
    if (PIX_DIV < 1 || H_FP < 1 || H_SYNC < 1 || H_BP < 1 ||
        V_FP < 1 || V_SYNC < 1 || V_BP < 1 ||
        H_TOTAL > 2048 || V_TOTAL > 1024) begin : g_param_err
        $error("vga_timing_gen: illegal parameter set");
    end

    logic [DIV_W-1:0]  div_q, div_d;
    logic [10:0]       col_q, col_d;
    logic [9:0]        row_q, row_d;
    logic [FCNT_W-1:0] fcnt_q, fcnt_d;
    logic              start_q, start_d;
    logic              hs_q, hs_d;
    logic              vs_q, vs_d;
    logic              blank_q, blank_d;
    logic              pix_en_q, pix_en_d;
    logic              line_q, line_d;
    logic              frame_q, frame_d;

    // Prescaler, position counters, strobes and sync/blank decode of the next position
    always_comb begin
        div_d    = div_q;
        col_d    = col_q;
        row_d    = row_q;
        fcnt_d   = fcnt_q;
        start_d  = start_q;
        pix_en_d = 1'b0;
        line_d   = 1'b0;
        frame_d  = 1'b0;
        if (en) begin
            if (start_q) begin
                // (0,0) is presented on the first enabled cycle after reset
                start_d  = 1'b0;
                pix_en_d = 1'b1;
            end else if (div_q == DIV_W'(PIX_DIV - 1)) begin
                div_d    = '0;
                pix_en_d = 1'b1;
                if (col_q == 11'(H_TOTAL - 1)) begin
                    col_d = '0;
                    if (row_q == 10'(V_TOTAL - 1)) begin
                        row_d  = '0;
                        fcnt_d = fcnt_q + FCNT_W'(1);
                    end else begin
                        row_d = row_q + 10'd1;
                    end
                end else begin
                    col_d = col_q + 11'd1;
                end
            end else begin
                div_d = div_q + DIV_W'(1);
            end
            line_d  = pix_en_d && (col_d == '0);
            frame_d = line_d && (row_d == '0);
        end
        hs_d    = (col_d >= 11'(HS_BEG) && col_d < 11'(HS_END)) ? HS_ON : ~HS_ON;
        vs_d    = (row_d >= 10'(VS_BEG) && row_d < 10'(VS_END)) ? VS_ON : ~VS_ON;
        blank_d = (col_d >= 11'(H_ACTIVE)) || (row_d >= 10'(V_ACTIVE));
    end

    // Timing state and registered outputs
    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset) begin
            div_q    <= '0;
            col_q    <= '0;
            row_q    <= '0;
            fcnt_q   <= '0;
            start_q  <= 1'b1;
            hs_q     <= ~HS_ON;
            vs_q     <= ~VS_ON;
            blank_q  <= 1'b0;
            pix_en_q <= 1'b0;
            line_q   <= 1'b0;
            frame_q  <= 1'b0;
        end else begin
            div_q    <= div_d;
            col_q    <= col_d;
            row_q    <= row_d;
            fcnt_q   <= fcnt_d;
            start_q  <= start_d;
            hs_q     <= hs_d;
            vs_q     <= vs_d;
            blank_q  <= blank_d;
            pix_en_q <= pix_en_d;
            line_q   <= line_d;
            frame_q  <= frame_d;
        end
    end

`ifdef VGA_TEST_PATTERN_EN
    // Bar k starts at the first col with col*8 >= k*H_ACTIVE
    function automatic logic [7:1][10:0] calc_thr();
        for (int unsigned k = 1; k < 8; k++) begin
            calc_thr[k] = 11'((k * H_ACTIVE + 7) / 8);
        end
    endfunction

    localparam logic [7:1][10:0] BAR_THR = calc_thr();

    logic [23:0] pat_q, pat_d;
    logic [2:0]  bar_c;

    // Colour-bar lookup for the next position, black while blanked
    always_comb begin
        bar_c = 3'd0;
        for (int k = 1; k < 8; k++) begin
            if (col_d >= BAR_THR[k]) begin
                bar_c = bar_c + 3'd1;
            end
        end
        case (bar_c)
            3'd0:    pat_d = 24'hFFFFFF;
            3'd1:    pat_d = 24'hFFFF00;
            3'd2:    pat_d = 24'h00FFFF;
            3'd3:    pat_d = 24'h00FF00;
            3'd4:    pat_d = 24'hFF00FF;
            3'd5:    pat_d = 24'hFF0000;
            3'd6:    pat_d = 24'h0000FF;
            default: pat_d = 24'h000000;
        endcase
        if (blank_d) begin
            pat_d = 24'h000000;
        end
    end

    // Pattern register, aligned with the coordinate registers
    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset) begin
            pat_q <= '0;
        end else begin
            pat_q <= pat_d;
        end
    end

    assign pat_rgb = pat_q;
`else
    assign pat_rgb = 24'h000000;
`endif

    assign HS          = hs_q;
    assign VS          = vs_q;
    assign blank       = blank_q;
    assign row         = row_q;
    assign col         = col_q;
    assign pix_en      = pix_en_q;
    assign line_start  = line_q;
    assign frame_start = frame_q;
    assign frame_cnt   = fcnt_q;

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Parametrised successor to the fixed 640x480 VGA sync generator; supports any resolution and porch set, an integer pixel-clock divider, and programmable sync polarity.
- Adds pixel/line/frame strobes, a frame counter and a run/freeze enable.
- Sits between the CLOCK_50 domain and the pixel renderer (paddles/ball/score); the renderer consumes row/col/pix_en and gates colour with blank.

Parameters:
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch (pixels)
H_SYNC, 96, HS pulse width (pixels)
H_BP, 48, horizontal back porch (pixels)
V_ACTIVE, 480, visible lines per frame
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, VS pulse width (lines)
V_BP, 33, vertical back porch (lines)
PIX_DIV, 2, CLOCK_50 cycles per pixel (>=1)
HS_POL, 0, asserted level of HS (0 = active-low)
VS_POL, 0, asserted level of VS (0 = active-low)
FCNT_W, 16, frame counter width

Ports:
CLOCK_50  input  1  system clock
reset  input  1  asynchronous, active-low reset
en  input  1  1 = run; 0 = freeze all counters and outputs
HS  output  1  horizontal sync, polarity HS_POL
VS  output  1  vertical sync, polarity VS_POL
blank  output  1  1 when (col,row) is outside the active area
row  output  10  current line, 0..V_TOTAL-1
col  output  11  current pixel, 0..H_TOTAL-1
pix_en  output  1  one-cycle strobe: a new pixel starts this cycle
line_start  output  1  strobe at col 0 (with pix_en)
frame_start  output  1  strobe at col 0, row 0 (with pix_en)
frame_cnt  output  FCNT_W  completed-frame count, wraps
pat_rgb  output  24  test-pattern colour (see Optional Feature)

Behaviour:
- Derived widths: H_TOTAL = sum of H_* (default 800); V_TOTAL = sum of V_* (default 525).
- Prescaler:
  - div_cnt counts 0..PIX_DIV-1 while en=1; pixel tick when div_cnt == PIX_DIV-1.
  - PIX_DIV=1 gives a tick every cycle.
- Counters:
  - On each tick, col increments; at H_TOTAL-1 it wraps to 0 and row increments.
  - row at V_TOTAL-1 with col wrap returns to 0; frame_cnt increments modulo 2^FCNT_W.
- Registered outputs: every output is registered and reflects the same (col,row) pair in the same cycle; no skew between sync, blank and coordinates.
- Decoding:
  - HS asserted iff H_ACTIVE+H_FP <= col < H_ACTIVE+H_FP+H_SYNC.
  - VS asserted iff V_ACTIVE+V_FP <= row < V_ACTIVE+V_FP+V_SYNC.
  - blank = (col >= H_ACTIVE) | (row >= V_ACTIVE); exact boundary, no off-by-one.
- Strobes:
  - pix_en is high for one cycle, the cycle in which a new (col,row) first appears.
  - line_start and frame_start are subsets of pix_en.
  - After reset, the first pix_en/line_start/frame_start occurs on the first cycle after reset deassertion with en=1.
- en=0:
  - div_cnt, col, row and frame_cnt hold; strobes forced 0; HS/VS/blank hold.
  - Re-enabling resumes without a lost or duplicated pixel.
- Reset (asserted at any time, including mid-line or mid-sync):
  - Immediately: col=0, row=0, div_cnt=0, frame_cnt=0, blank=0, HS=VS=deasserted level, strobes=0, pat_rgb=0.
- Elaboration check: error if PIX_DIV<1, any porch/sync parameter <1, H_TOTAL>2048 or V_TOTAL>1024.

Optional Feature:
- Macro: VGA_TEST_PATTERN_EN.
- When defined:
  - pat_rgb is a registered 8-bar colour pattern, bar index = col*8/H_ACTIVE (integer division, computed by comparison against precomputed thresholds, no divider).
  - Bar colours, in order: white FFFFFF, yellow FFFF00, cyan 00FFFF, green 00FF00, magenta FF00FF, red FF0000, blue 0000FF, black 000000.
  - pat_rgb = 0 whenever blank=1.
  - pat_rgb is aligned with the same (col,row) as the other outputs.
- When undefined: pat_rgb tied to 0; no pattern logic synthesised.

Test Plan:
- Defaults, release reset with en=1 -> first cycle: col=0, row=0, blank=0, HS=1, VS=1, pix_en=frame_start=line_start=1; col=1 two cycles later.
- Run one line -> HS low exactly for col 656..751 (192 CLOCK_50 cycles); blank rises at col 640; row increments to 1 when col wraps from 799 to 0.
- Run one frame -> VS low only for rows 490..491; frame_start again after 800*525*2 = 840000 cycles; frame_cnt=1.
- Pulse en=0 for 7 cycles at col=300 -> col stays 300, no pix_en; after en=1, next pixel col=301 with no skips.
- Assert reset at row=491, col=700 (HS and VS active) -> same cycle: HS=VS=1, col=row=0, frame_cnt=0.
- With VGA_TEST_PATTERN_EN, PIX_DIV=1 -> col 0..79 pat_rgb=FFFFFF, col 80 =FFFF00, col 639 =000000, col 640 =000000 with blank=1; without the macro, pat_rgb=0 throughout.
